// File: rtl/fifo_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_stream_pkg
// Brief   : Shared widths, occupancy encoding and counter sizing for the
//           FIFO stream reader.
// Rev     : 1.0  initial release
// ============================================================================
package fifo_stream_pkg;

    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    // A one-beat packet still needs a 1-bit counter to keep the datapath legal.
    function automatic int cnt_width(input int pkt_len);
        return (pkt_len <= 1) ? 1 : $clog2(pkt_len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_out_buf.sv
`default_nettype none
// ============================================================================
// Module  : stream_out_buf
// Brief   : 2-entry FIFO-ordered valid/ready output buffer; head entry drives
//           the stream outputs directly from registers.
// Rev     : 1.0  initial release
// ============================================================================
module stream_out_buf
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_occ;
    logic             w_pop;

    assign valid     = (r_occ != OCC_EMPTY);
    assign head      = r_head;
    assign occupancy = r_occ;
    assign w_pop     = valid & ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= OCC_EMPTY;
        end else begin
            case (r_occ)
                OCC_EMPTY: begin
                    if (push) begin
                        r_head <= push_data;
                        r_occ  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && w_pop) begin
                        r_head <= push_data;
                    end else if (push) begin
                        r_tail <= push_data;
                        r_occ  <= OCC_TWO;
                    end else if (w_pop) begin
                        r_occ  <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // The read-issue rule upstream guarantees no push lands here.
                    if (w_pop) begin
                        r_head <= r_tail;
                        r_occ  <= OCC_ONE;
                    end
                end
                default: r_occ <= OCC_EMPTY;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !w_pop && (r_occ == OCC_TWO)));

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module  : fifo_stream_reader
// Brief   : Drains an 8-bit synchronous FIFO into a valid/ready stream with
//           fixed-length packet framing on m_last.
// Rev     : 1.0  initial release
// ============================================================================
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PKT_LEN = 4,
    parameter int CNT_W   = cnt_width(PKT_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [1:0]        occupancy
);

    logic             r_inflight;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             w_pop;
    logic             w_last;
    logic [2:0]       w_level;
    logic [DATA_W:0]  w_head;

    assign w_pop = m_valid & m_ready;

    // Buffer level after this edge, counting the byte already on its way.
    assign w_level    = {1'b0, occupancy} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fifo_rd_en = en & ~fifo_empty & ~rst & (w_level < 3'd2);

    // Counted at capture time: the buffer is FIFO-ordered and never drops a
    // beat, so the capture index equals the accepted-beat index.
    assign w_last = (r_beat_cnt == CNT_W'(PKT_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (r_inflight) begin
                r_beat_cnt <= w_last ? '0 : r_beat_cnt + CNT_W'(1);
            end
        end
    end

    stream_out_buf #(
        .WIDTH (DATA_W + 1)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (r_inflight),
        .push_data ({w_last, fifo_data}),
        .ready     (m_ready),
        .valid     (m_valid),
        .head      (w_head),
        .occupancy (occupancy)
    );

    assign m_last = w_head[DATA_W];
    assign m_data = w_head[DATA_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_stream_reader
// Brief   : Bench with a behavioural FIFO and a scoreboard of expected beats.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fifo_stream_reader;

    localparam int DATA_W  = 8;
    localparam int PKT_LEN = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              fifo_empty = 1'b1;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              fifo_rd_en;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic [1:0]        occupancy;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_W  (DATA_W),
        .PKT_LEN (PKT_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .occupancy  (occupancy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int beat_cnt = 0;
    logic rd_seen = 1'b0;

    logic [DATA_W-1:0] mem[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W:0]   seen[$];
    int                seen_cyc[$];

    // Behavioural FIFO: registered data_out and registered empty flag.
    always @(negedge clk) rd_seen = fifo_rd_en;

    always @(posedge clk) begin
        cyc++;
        if (rd_seen && !rst) begin
            checks++;
            if (mem.size() == 0) begin
                errors++;
                $display("FAIL fifo_underflow rd_en=1 while model FIFO empty");
            end else begin
                fifo_data <= mem.pop_front();
            end
        end
        fifo_empty <= (mem.size() == 0);
    end

    // Scoreboard: every accepted beat must be the next expected byte.
    always @(negedge clk) begin
        logic [DATA_W-1:0] e;
        logic              el;
        if (!rst && m_valid && m_ready) begin
            checks++;
            el = (beat_cnt == PKT_LEN - 1);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected got data=%02h last=%0b, expected none", m_data, m_last);
            end else begin
                e = exp_q.pop_front();
                if (m_data !== e || m_last !== el) begin
                    errors++;
                    $display("FAIL beat got data=%02h last=%0b, expected data=%02h last=%0b",
                             m_data, m_last, e, el);
                end
            end
            beat_cnt = (beat_cnt == PKT_LEN - 1) ? 0 : beat_cnt + 1;
            seen.push_back({m_last, m_data});
            seen_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [DATA_W-1:0] b);
        mem.push_back(b);
        exp_q.push_back(b);
    endtask

    // Assert reset and drop every expected byte that already left the FIFO.
    task automatic assert_reset();
        int d;
        rst = 1'b1;
        d = exp_q.size() - mem.size();
        for (int i = 0; i < d; i++) void'(exp_q.pop_front());
        beat_cnt = 0;
        seen.delete();
        seen_cyc.delete();
    endtask

    task automatic pulse_reset();
        assert_reset();
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_valid, m_data, m_last, occupancy, fifo_rd_en} !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%0b d=%02h l=%0b occ=%0d rd=%0b, expected all 0",
                     m_valid, m_data, m_last, occupancy, fifo_rd_en);
        end
        @(posedge clk); #1;
        en = 1'b1;
        m_ready = 1'b0;
        load(8'h5A);
        load(8'h3C);
        tick(6);
        checks++;
        if (occupancy !== 2'd2 || m_data !== 8'h5A) begin
            errors++;
            $display("FAIL reset_precond got occ=%0d d=%02h, expected occ=2 d=5a", occupancy, m_data);
        end
        #2;
        assert_reset();
        #1;
        checks++;
        if ({m_valid, m_data, m_last, occupancy, fifo_rd_en} !== '0) begin
            errors++;
            $display("FAIL reset_async got v=%0b d=%02h l=%0b occ=%0d rd=%0b, expected all 0",
                     m_valid, m_data, m_last, occupancy, fifo_rd_en);
        end
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_single();
        int rd_idx = -1, rd_cnt = 0, v_idx = -1, v_cnt = 0;
        logic [DATA_W:0] v_beat = '0;
        pulse_reset();
        en = 1'b1;
        m_ready = 1'b1;
        load(8'hA5);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fifo_rd_en) begin rd_cnt++; rd_idx = i; end
            if (m_valid) begin v_cnt++; v_idx = i; v_beat = {m_last, m_data}; end
        end
        checks++;
        if (rd_cnt != 1 || v_cnt != 1) begin
            errors++;
            $display("FAIL single_counts got rd=%0d valid=%0d, expected 1 and 1", rd_cnt, v_cnt);
        end
        checks++;
        if (v_idx != rd_idx + 2 || v_beat !== {1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL single_latency got rd@%0d valid@%0d beat=%03h, expected valid@rd+2 beat=0a5",
                     rd_idx, v_idx, v_beat);
        end
    endtask

    task automatic test_streaming();
        int t = 0;
        pulse_reset();
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) load(8'(i));
        while (seen.size() < 8 && t < 40) begin @(negedge clk); t++; end
        checks++;
        if (seen.size() != 8) begin
            errors++;
            $display("FAIL stream_count got %0d beats, expected 8", seen.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (seen[k] !== {(k == 3 || k == 7), 8'(k)}) begin
                    errors++;
                    $display("FAIL stream_beat%0d got %03h, expected last=%0b data=%02h",
                             k, seen[k], (k == 3 || k == 7), k);
                end
            end
            checks++;
            if (seen_cyc[7] - seen_cyc[0] != 7) begin
                errors++;
                $display("FAIL stream_bubbles got span %0d cycles, expected 7", seen_cyc[7] - seen_cyc[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        int t = 0;
        logic [DATA_W-1:0] held;
        pulse_reset();
        en = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) load(8'h10 + 8'(i));
        while (seen.size() < 1 && t < 20) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        m_ready = 1'b0;
        @(negedge clk);
        held = m_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (m_data !== held || m_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold got v=%0b d=%02h, expected v=1 d=%02h", m_valid, m_data, held);
            end
        end
        checks++;
        if (occupancy !== 2'd2 || fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got occ=%0d rd=%0b, expected occ=2 rd=0", occupancy, fifo_rd_en);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        t = 0;
        while (seen.size() < 8 && t < 40) begin @(negedge clk); t++; end
        tick(3);
        checks++;
        if (seen.size() != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_total got %0d beats %0d pending, expected 8 and 0", seen.size(), exp_q.size());
        end
    endtask

    task automatic test_en_drop();
        int t = 0, rd = 0, extra = 0;
        en = 1'b0;
        pulse_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) load(8'h20 + 8'(i));
        en = 1'b1;
        while (rd < 3 && t < 20) begin
            @(negedge clk);
            t++;
            if (fifo_rd_en) rd++;
        end
        @(posedge clk); #1;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_rd_en) extra++;
        end
        checks++;
        if (rd != 3 || extra != 0) begin
            errors++;
            $display("FAIL en_stop got reads=%0d extra=%0d, expected 3 and 0", rd, extra);
        end
        checks++;
        if (seen.size() != 3 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL en_drain got %0d beats v=%0b, expected 3 beats v=0", seen.size(), m_valid);
        end
        @(posedge clk); #1;
        en = 1'b1;
        t = 0;
        while (seen.size() < 6 && t < 30) begin @(negedge clk); t++; end
        checks++;
        if (seen.size() != 6 || seen[3][DATA_W-1:0] !== 8'h23) begin
            errors++;
            $display("FAIL en_resume got %0d beats, 4th=%03h, expected 6 beats 4th data=23",
                     seen.size(), (seen.size() > 3) ? seen[3] : 9'h0);
        end
    endtask

    task automatic test_reset_full();
        int t = 0;
        pulse_reset();
        en = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) load(8'h30 + 8'(i));
        while (occupancy !== 2'd2 && t < 20) begin @(negedge clk); t++; end
        checks++;
        if (occupancy !== 2'd2) begin
            errors++;
            $display("FAIL rstfull_fill got occ=%0d, expected 2", occupancy);
        end
        @(posedge clk); #1;
        assert_reset();
        @(negedge clk);
        checks++;
        if ({m_valid, m_data, m_last, occupancy, fifo_rd_en} !== '0) begin
            errors++;
            $display("FAIL rstfull_clear got v=%0b d=%02h l=%0b occ=%0d rd=%0b, expected all 0",
                     m_valid, m_data, m_last, occupancy, fifo_rd_en);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_ready = 1'b1;
        t = 0;
        while (seen.size() < 6 && t < 40) begin @(negedge clk); t++; end
        checks++;
        if (seen.size() != 6) begin
            errors++;
            $display("FAIL rstfull_count got %0d beats, expected 6", seen.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (seen[k] !== {(k == 3), 8'h32 + 8'(k)}) begin
                    errors++;
                    $display("FAIL rstfull_beat%0d got %03h, expected last=%0b data=%02h",
                             k, seen[k], (k == 3), 8'h32 + 8'(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_en_drop();
        test_reset_full();
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
